muldiv_ctrl: RTL

- Issue and commit controller for the shared iterative multiply/divide engine in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and starts the engine with a start/done handshake.
- Generates the EX stall, aborts in-flight operations on pipeline flush, and owns the architectural HI/LO registers.
- HI/LO are updated only when the instruction retires out of EX, which keeps exceptions precise.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/hilo_regs.sv | 36 +++
 rtl/muldiv_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_pkg: opcode and FSM state types for the mul/div controller  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MULT = 3'd1,
    OP_DIV  = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_HOLD  = 2'd3
  } muldiv_state_t;

  function automatic logic is_engine_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_regs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hilo_regs: architectural HI/LO with retire-commit and MT writes    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [WIDTH-1:0] commit_hi,
  input  logic [WIDTH-1:0] commit_lo,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // commit only happens in HOLD and MT writes only in IDLE, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= commit_hi;
      lo <= commit_lo;
    end else begin
      if (mthi_we) hi <= mt_data;
      if (mtlo_we) lo <= mt_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_ctrl: issue/commit control for the iterative mul/div engine |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  muldiv_op_t       op,
  input  logic             op_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             reg_stall,
  output logic             ctrl_stall,
  output logic             eng_start,
  output logic             eng_is_div,
  output logic             eng_sign,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic             eng_abort,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_hi,
  input  logic [WIDTH-1:0] eng_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    r_state;
  logic [WIDTH-1:0] r_pending_hi;
  logic [WIDTH-1:0] r_pending_lo;

  logic w_idle;
  logic w_issue;
  logic w_div0;
  logic w_mt_ok;
  logic w_commit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_issue  = w_idle && op_valid && is_engine_op(op) && !flush;
  assign w_div0   = (op == OP_DIV) && (src_b == '0);
  assign w_mt_ok  = w_idle && op_valid && !reg_stall && !flush;
  assign w_commit = (r_state == ST_HOLD) && !reg_stall && !flush;

  // Stall starts in the issue cycle so EX holds the instruction until HOLD
  assign ctrl_stall = w_issue || (r_state == ST_START) || (r_state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pending_hi <= '0;
      r_pending_lo <= '0;
      eng_a        <= '0;
      eng_b        <= '0;
      eng_sign     <= 1'b0;
      eng_is_div   <= 1'b0;
      eng_start    <= 1'b0;
      eng_abort    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            eng_a      <= src_a;
            eng_b      <= src_b;
            eng_sign   <= op_sign;
            eng_is_div <= (op == OP_DIV);
            // Divide by zero bypasses the engine with a fixed result
            if (w_div0) begin
              r_pending_hi <= src_a;
              r_pending_lo <= '1;
              r_state      <= ST_HOLD;
            end else begin
              eng_start <= 1'b1;
              r_state   <= ST_START;
            end
          end
        end
        ST_START: begin
          if (flush) begin
            eng_abort <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            eng_abort <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (eng_done) begin
            r_pending_hi <= eng_hi;
            r_pending_lo <= eng_lo;
            r_state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (flush || !reg_stall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .commit   (w_commit),
    .commit_hi(r_pending_hi),
    .commit_lo(r_pending_lo),
    .mthi_we  (w_mt_ok && (op == OP_MTHI)),
    .mtlo_we  (w_mt_ok && (op == OP_MTLO)),
    .mt_data  (src_a),
    .hi       (hi),
    .lo       (lo)
  );

endmodule
`default_nettype wire
